// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared constants for the machine-mode trap sequencer.
//   - XLEN and the FSM state encoding
//   - interrupt cause codes (sw = 3, timer = 7, ext = 11)
//   - MSTATUS bit positions and the MCAUSE interrupt bit
//   - helpers that build the MSTATUS value written on trap entry and on mret
package trap_controller_pkg;

    localparam int unsigned XLEN = 32;

    // FSM encoding kept as plain constants so legacy code can compare against it
    localparam logic [2:0] ST_RESET_REDIR = 3'd0;
    localparam logic [2:0] ST_IDLE        = 3'd1;
    localparam logic [2:0] ST_SAVE        = 3'd2;
    localparam logic [2:0] ST_STATUS      = 3'd3;
    localparam logic [2:0] ST_RET         = 3'd4;
    localparam logic [2:0] ST_REDIR       = 3'd5;

    localparam logic [4:0] IRQ_CODE_SW    = 5'd3;
    localparam logic [4:0] IRQ_CODE_TIMER = 5'd7;
    localparam logic [4:0] IRQ_CODE_EXT   = 5'd11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MCAUSE_IRQ_BIT = XLEN - 1;

    // Clears the two low bits of a PC / vector base
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
    function automatic logic [XLEN-1:0] entry_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                = s;
        r[MSTATUS_MPIE]                  = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mret: MIE <- MPIE, MPIE <- 1, MPP <- M
    function automatic logic [XLEN-1:0] return_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                = s;
        r[MSTATUS_MIE]                   = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                  = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: CSR-side bundle between the trap sequencer and the CSR block.
//   *_reg   : current CSR values (CSR block -> sequencer)
//   *_in    : hardware write data (sequencer -> CSR block)
//   *_write : hardware write strobes (sequencer -> CSR block)
// master = trap sequencer, slave = CSR block.
interface trap_controller_if;
    import trap_controller_pkg::*;

    logic [XLEN-1:0] mstatus_reg;
    logic [XLEN-1:0] mie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;

    logic [XLEN-1:0] mepc_in;
    logic [XLEN-1:0] mcause_in;
    logic [XLEN-1:0] mtval_in;
    logic [XLEN-1:0] mstatus_in;
    logic            mepc_write;
    logic            mcause_write;
    logic            mtval_write;
    logic            mstatus_write;

    modport master (
        input  mstatus_reg, mie_reg, mtvec_reg, mepc_reg,
        output mepc_in, mcause_in, mtval_in, mstatus_in,
        output mepc_write, mcause_write, mtval_write, mstatus_write
    );

    modport slave (
        output mstatus_reg, mie_reg, mtvec_reg, mepc_reg,
        input  mepc_in, mcause_in, mtval_in, mstatus_in,
        input  mepc_write, mcause_write, mtval_write, mstatus_write
    );

endinterface

// File: rtl/trap_controller_irq_prio.sv
// trap_irq_prio: combinational interrupt priority encoder.
//   pending : mip & mie_reg
//   any     : at least one enabled interrupt pending
//   code    : cause code of the winner, ext (11) > sw (3) > timer (7)
module trap_irq_prio
    import trap_controller_pkg::*;
(
    input  logic [XLEN-1:0] pending,
    output logic            any,
    output logic [4:0]      code
);

    always_comb begin
        // only bits 3/7/11 can be set, so a full OR-reduce is equivalent
        any  = |pending;
        code = '0;
        if (pending[IRQ_CODE_EXT]) begin
            code = IRQ_CODE_EXT;
        end else if (pending[IRQ_CODE_SW]) begin
            code = IRQ_CODE_SW;
        end else if (pending[IRQ_CODE_TIMER]) begin
            code = IRQ_CODE_TIMER;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer.
// Accepts exceptions, mret and interrupts in IDLE, then sequences the CSR
// writes (MEPC/MCAUSE/MTVAL, then MSTATUS) and a one-cycle PC redirect.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   exc_*               synchronous exception (valid, cause, tval, pc)
//   mret                mret retiring
//   boundary, next_pc   interrupt window and the PC saved for interrupts
//   timeint/swint/extint machine interrupt levels; debug masks them
//   csr                 CSR bundle (current values in, write data/strobes out)
//   mip                 pending vector (bits 3/7/11)
//   busy                pipeline stall
//   redirect/redirect_pc one-cycle PC redirect
// Build option: TRAP__VECTORED_MODE_EN enables vectored interrupt targets
// when mtvec_reg[1:0] == 2'b01.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] ResetPc = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exc_valid,
    input  logic [4:0]          exc_cause,
    input  logic [XLEN-1:0]     exc_tval,
    input  logic [XLEN-1:0]     exc_pc,
    input  logic                mret,
    input  logic                boundary,
    input  logic [XLEN-1:0]     next_pc,
    input  logic                timeint,
    input  logic                swint,
    input  logic                extint,
    input  logic                debug,
    trap_controller_if.master   csr,
    output logic [XLEN-1:0]     mip,
    output logic                busy,
    output logic                redirect,
    output logic [XLEN-1:0]     redirect_pc
);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ret_q, ret_d;

    logic [XLEN-1:0] mip_vec;
    logic [XLEN-1:0] pending;
    logic            irq_any;
    logic [4:0]      irq_code;
    logic            irq_take;
    logic            accept;
    logic [XLEN-1:0] trap_target;

    always_comb begin
        mip_vec                 = '0;
        mip_vec[IRQ_CODE_SW]    = swint;
        mip_vec[IRQ_CODE_TIMER] = timeint;
        mip_vec[IRQ_CODE_EXT]   = extint;
        pending                 = mip_vec & csr.mie_reg;
    end

    trap_irq_prio u_prio (
        .pending (pending),
        .any     (irq_any),
        .code    (irq_code)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        tval_d   = tval_q;
        pc_d     = pc_q;
        ret_d    = ret_q;
        accept   = 1'b0;
        irq_take = boundary && csr.mstatus_reg[MSTATUS_MIE] && !debug && irq_any;
        case (state_q)
            ST_RESET_REDIR: state_d = ST_IDLE;
            ST_IDLE: begin
                if (exc_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SAVE;
                    ret_d   = 1'b0;
                    cause_d = XLEN'(exc_cause);
                    tval_d  = exc_tval;
                    pc_d    = exc_pc & ALIGN_MASK;
                end else if (mret) begin
                    accept  = 1'b1;
                    state_d = ST_RET;
                    ret_d   = 1'b1;
                end else if (irq_take) begin
                    accept                  = 1'b1;
                    state_d                 = ST_SAVE;
                    ret_d                   = 1'b0;
                    cause_d                 = '0;
                    cause_d[MCAUSE_IRQ_BIT] = 1'b1;
                    cause_d[4:0]            = irq_code;
                    tval_d                  = '0;
                    pc_d                    = next_pc & ALIGN_MASK;
                end
            end
            ST_SAVE:   state_d = ST_STATUS;
            ST_STATUS: state_d = ST_REDIR;
            ST_RET:    state_d = ST_REDIR;
            ST_REDIR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET_REDIR;
            cause_q <= '0;
            tval_q  <= '0;
            pc_q    <= '0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        trap_target = csr.mtvec_reg & ALIGN_MASK;
`ifdef TRAP__VECTORED_MODE_EN
        if (csr.mtvec_reg[1:0] == 2'b01 && cause_q[MCAUSE_IRQ_BIT]) begin
            trap_target = (csr.mtvec_reg & ALIGN_MASK) + XLEN'({cause_q[4:0], 2'b00});
        end
`endif
    end

    // Outputs decode the state but are forced low while rst_n is asserted, so
    // a reset landing mid-sequence suppresses that cycle's CSR write.
    always_comb begin
        csr.mepc_in       = '0;
        csr.mcause_in     = '0;
        csr.mtval_in      = '0;
        csr.mstatus_in    = '0;
        csr.mepc_write    = 1'b0;
        csr.mcause_write  = 1'b0;
        csr.mtval_write   = 1'b0;
        csr.mstatus_write = 1'b0;
        mip               = '0;
        busy              = 1'b0;
        redirect          = 1'b0;
        redirect_pc       = '0;
        if (rst_n) begin
            mip = mip_vec;
            case (state_q)
                ST_RESET_REDIR: begin
                    busy        = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = ResetPc;
                end
                ST_IDLE: busy = accept;
                ST_SAVE: begin
                    busy             = 1'b1;
                    csr.mepc_write   = 1'b1;
                    csr.mcause_write = 1'b1;
                    csr.mtval_write  = 1'b1;
                    csr.mepc_in      = pc_q;
                    csr.mcause_in    = cause_q;
                    csr.mtval_in     = tval_q;
                end
                ST_STATUS: begin
                    busy              = 1'b1;
                    csr.mstatus_write = 1'b1;
                    csr.mstatus_in    = entry_status(csr.mstatus_reg);
                end
                ST_RET: begin
                    busy              = 1'b1;
                    csr.mstatus_write = 1'b1;
                    csr.mstatus_in    = return_status(csr.mstatus_reg);
                end
                ST_REDIR: begin
                    busy        = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = ret_q ? (csr.mepc_reg & ALIGN_MASK) : trap_target;
                end
                default: busy = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
    import trap_controller_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n, exc_valid, mret, boundary, timeint, swint, extint, debug;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval, exc_pc, next_pc, mip, redirect_pc;
    logic        busy, redirect;

    always #5 clk = ~clk;

    trap_controller_if csr ();

    trap_controller #(.ResetPc(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_tval    (exc_tval),
        .exc_pc      (exc_pc),
        .mret        (mret),
        .boundary    (boundary),
        .next_pc     (next_pc),
        .timeint     (timeint),
        .swint       (swint),
        .extint      (extint),
        .debug       (debug),
        .csr         (csr),
        .mip         (mip),
        .busy        (busy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of the per-cycle actions still owed after an
    // acceptance; an empty queue means the sequencer is idle.
    typedef enum int {A_RESET, A_SAVE, A_ENTRY, A_RET, A_RTRAP, A_RRET} act_e;
    act_e        q[$];
    logic [31:0] cap_cause, cap_tval, cap_pc;
    logic        w_mepc_en, w_mst_en;
    logic [31:0] w_mepc, w_mst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_entry(input logic [31:0] s);
        logic [31:0] mie_bit;
        mie_bit = (s >> 3) & 32'h1;
        return (s & ~32'h88) | (mie_bit << 7) | 32'h1800;
    endfunction

    function automatic logic [31:0] m_return(input logic [31:0] s);
        logic [31:0] mpie_bit;
        mpie_bit = (s >> 7) & 32'h1;
        return (s & ~32'h88) | (mpie_bit << 3) | 32'h80 | 32'h1800;
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] base;
        logic [31:0] vec;
        base = csr.mtvec_reg & ~32'h3;
        vec  = csr.mtvec_reg;
`ifdef TRAP__VECTORED_MODE_EN
        if (vec[1:0] == 2'b01 && cap_cause[31]) return base + 4 * (cap_cause & 32'h1F);
`endif
        return base;
    endfunction

    // Settle the combinational outputs of the current cycle and compare them
    // with what the model owes for this cycle.
    task automatic settle_check();
        logic [31:0] e_mip, pend;
        logic [3:0]  e_we;
        logic        e_busy, e_red;
        logic [31:0] e_rpc, e_mepc, e_mcause, e_mtval, e_mst;
        act_e        a;
        #1;
        e_mip = '0; e_we = '0; e_busy = 1'b0; e_red = 1'b0;
        e_rpc = '0; e_mepc = '0; e_mcause = '0; e_mtval = '0; e_mst = '0;
        w_mepc_en = 1'b0; w_mst_en = 1'b0;
        if (!rst_n) begin
            q.delete();
            q.push_back(A_RESET);
        end else begin
            e_mip[11] = extint;
            e_mip[7]  = timeint;
            e_mip[3]  = swint;
            if (q.size() > 0) begin
                a      = q.pop_front();
                e_busy = 1'b1;
                case (a)
                    A_RESET: begin e_red = 1'b1; e_rpc = RESET_PC; end
                    A_SAVE: begin
                        e_we = 4'b1110; e_mepc = cap_pc; e_mcause = cap_cause; e_mtval = cap_tval;
                        w_mepc_en = 1'b1; w_mepc = cap_pc;
                    end
                    A_ENTRY: begin
                        e_we = 4'b0001; e_mst = m_entry(csr.mstatus_reg);
                        w_mst_en = 1'b1; w_mst = e_mst;
                    end
                    A_RET: begin
                        e_we = 4'b0001; e_mst = m_return(csr.mstatus_reg);
                        w_mst_en = 1'b1; w_mst = e_mst;
                    end
                    A_RTRAP: begin e_red = 1'b1; e_rpc = m_target(); end
                    A_RRET:  begin e_red = 1'b1; e_rpc = csr.mepc_reg & ~32'h3; end
                    default: ;
                endcase
            end else begin
                pend = e_mip & csr.mie_reg;
                if (exc_valid) begin
                    e_busy = 1'b1;
                    cap_cause = 32'(exc_cause); cap_tval = exc_tval; cap_pc = exc_pc & ~32'h3;
                    q.push_back(A_SAVE); q.push_back(A_ENTRY); q.push_back(A_RTRAP);
                end else if (mret) begin
                    e_busy = 1'b1;
                    q.push_back(A_RET); q.push_back(A_RRET);
                end else if (boundary && csr.mstatus_reg[3] && !debug && pend != 0) begin
                    e_busy = 1'b1;
                    cap_cause = 32'h8000_0000 | (pend[11] ? 32'd11 : (pend[3] ? 32'd3 : 32'd7));
                    cap_tval  = '0;
                    cap_pc    = next_pc & ~32'h3;
                    q.push_back(A_SAVE); q.push_back(A_ENTRY); q.push_back(A_RTRAP);
                end
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("redirect", 32'(redirect), 32'(e_red));
        chk("strobes", 32'({csr.mepc_write, csr.mcause_write, csr.mtval_write, csr.mstatus_write}), 32'(e_we));
        chk("mip", mip, e_mip);
        if (e_red || !rst_n) chk("redirect_pc", redirect_pc, e_rpc);
        if (e_we[3] || !rst_n) begin
            chk("mepc_in", csr.mepc_in, e_mepc);
            chk("mcause_in", csr.mcause_in, e_mcause);
            chk("mtval_in", csr.mtval_in, e_mtval);
        end
        if (e_we[0] || !rst_n) chk("mstatus_in", csr.mstatus_in, e_mst);
    endtask

    // Clock edge, then commit the CSR writes the model expected (CSR block).
    task automatic advance();
        @(posedge clk);
        #1;
        if (w_mepc_en) csr.mepc_reg = w_mepc;
        if (w_mst_en)  csr.mstatus_reg = w_mst;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; exc_valid = 1'b0; mret = 1'b0; boundary = 1'b0;
        timeint = 1'b0; swint = 1'b0; extint = 1'b0; debug = 1'b0;
        exc_cause = '0; exc_tval = '0; exc_pc = '0; next_pc = '0;
        csr.mstatus_reg = '0; csr.mie_reg = '0; csr.mtvec_reg = '0; csr.mepc_reg = '0;
        w_mepc_en = 1'b0; w_mst_en = 1'b0; w_mepc = '0; w_mst = '0;
        cap_cause = '0; cap_tval = '0; cap_pc = '0;

        // reset, then the reset redirect
        settle_check(); advance();
        settle_check(); advance();
        rst_n = 1'b1;
        settle_check();
        chk("reset_redirect", 32'(redirect), 32'd1);
        chk("reset_redirect_pc", redirect_pc, 32'h100);
        advance();
        settle_check();
        chk("idle_after_reset", 32'(redirect), 32'd0);
        advance();

        // exception trap
        csr.mstatus_reg = 32'h8; csr.mtvec_reg = 32'h4000;
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h2002; exc_tval = 32'hDEAD;
        settle_check();
        chk("exc_accept_busy", 32'(busy), 32'd1);
        advance();
        exc_valid = 1'b0;
        settle_check();
        chk("exc_mepc", csr.mepc_in, 32'h2000);
        chk("exc_mcause", csr.mcause_in, 32'h2);
        chk("exc_mtval", csr.mtval_in, 32'hDEAD);
        advance();
        settle_check();
        chk("exc_mstatus", csr.mstatus_in, 32'h1880);
        advance();
        settle_check();
        chk("exc_redirect_pc", redirect_pc, 32'h4000);
        advance();
        settle_check(); advance();

        // all three interrupts: external wins
        csr.mstatus_reg = 32'h8; csr.mie_reg = 32'h888; csr.mtvec_reg = 32'h1001;
        extint = 1'b1; swint = 1'b1; timeint = 1'b1; boundary = 1'b1; next_pc = 32'h40;
        settle_check(); advance();
        extint = 1'b0; swint = 1'b0; timeint = 1'b0; boundary = 1'b0;
        settle_check();
        chk("irq_mcause", csr.mcause_in, 32'h8000_000B);
        chk("irq_mepc", csr.mepc_in, 32'h40);
        chk("irq_mtval", csr.mtval_in, 32'h0);
        advance();
        settle_check(); advance();
        settle_check();
`ifdef TRAP__VECTORED_MODE_EN
        chk("irq_redirect_vectored", redirect_pc, 32'h102C);
`else
        chk("irq_redirect_direct", redirect_pc, 32'h1000);
`endif
        advance();
        settle_check(); advance();

        // mret restores MIE, then the pending timer interrupt is taken
        csr.mstatus_reg = 32'h80; csr.mepc_reg = 32'h3000; csr.mie_reg = 32'h80;
        csr.mtvec_reg = 32'h5000; timeint = 1'b1; boundary = 1'b1; next_pc = 32'h3000;
        mret = 1'b1;
        settle_check(); advance();
        mret = 1'b0;
        settle_check();
        chk("mret_mstatus", csr.mstatus_in, 32'h1888);
        advance();
        settle_check();
        chk("mret_redirect_pc", redirect_pc, 32'h3000);
        advance();
        settle_check();
        chk("timer_after_mret_busy", 32'(busy), 32'd1);
        advance();
        timeint = 1'b0;
        settle_check();
        chk("timer_mcause", csr.mcause_in, 32'h8000_0007);
        advance();
        settle_check(); advance();
        settle_check(); advance();
        settle_check(); advance();

        // exception and mret together, reset during STATUS
        csr.mstatus_reg = 32'h8; exc_valid = 1'b1; mret = 1'b1;
        exc_cause = 5'd4; exc_pc = 32'h7777; exc_tval = 32'h1234;
        settle_check(); advance();
        exc_valid = 1'b0; mret = 1'b0;
        settle_check();
        chk("both_mcause", csr.mcause_in, 32'h4);
        advance();
        rst_n = 1'b0;
        settle_check();
        chk("reset_in_status_no_write", 32'(csr.mstatus_write), 32'd0);
        advance();
        settle_check(); advance();
        rst_n = 1'b1;
        settle_check();
        chk("reset_redirect_again", redirect_pc, 32'h100);
        advance();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (q.size() == 0 && rst_n) begin
                exc_valid = ($urandom_range(0, 7) == 0);
                mret      = ($urandom_range(0, 7) == 0);
            end else begin
                exc_valid = 1'b0;
                mret      = 1'b0;
            end
            exc_cause = 5'($urandom);
            exc_tval  = $urandom;
            exc_pc    = $urandom;
            next_pc   = $urandom;
            timeint   = ($urandom_range(0, 3) == 0);
            swint     = ($urandom_range(0, 3) == 0);
            extint    = ($urandom_range(0, 3) == 0);
            boundary  = ($urandom_range(0, 1) == 0);
            debug     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) csr.mie_reg = $urandom;
            if ($urandom_range(0, 9) == 0) csr.mtvec_reg = $urandom;
            if ($urandom_range(0, 9) == 0) csr.mepc_reg = $urandom;
            if ($urandom_range(0, 5) == 0) csr.mstatus_reg = $urandom | 32'h8;
            settle_check();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
